seq_bus_datapath: RTL

- Parametrised successor to the single-bus datapath, with an internal microstep sequencer replacing externally driven Rin/Rout/MARin/MDRin strobes.
- Autonomously fetches, decodes and executes a Mini-SRC-format instruction subset over a req/ack memory handshake.
- Sits between the top-level CPU wrapper and the memory/RAM block.
- Exposes halt/illegal status and a debug register read port for testbenches and the board.

---
 rtl/seq_bus_datapath.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_bus_datapath.sv
// Single-bus datapath with an internal microstep sequencer running a Mini-SRC subset
// over a req/ack memory port. Define SEQ_DP_TRACE_EN to add the retire_* trace ports.
module seq_bus_datapath #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [3:0]        dbg_rsel,
  output logic [DATA_W-1:0] dbg_rdata
`ifdef SEQ_DP_TRACE_EN
  ,
  output logic              retire_valid,
  output logic [ADDR_W-1:0] retire_pc,
  output logic [DATA_W-1:0] retire_wdata
`endif
);

  localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
    OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110, OP_NOP  = 5'b11010, OP_HALT = 5'b11011
  } op_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, mar_q, mar_d;
  logic [31:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d, y_q, y_d, z_q, z_d;
  logic                illegal_q, illegal_d;
  logic                armed_q, armed_d;
  logic [DATA_W-1:0]   regs_q [NREG];

  logic                wb_en;
  logic [DATA_W-1:0]   wb_data;
  logic                ack_ok;

  op_e                 op;
  logic [RW-1:0]       ra, rb, rc;
  logic [DATA_W-1:0]   c_ext;
  logic                is_ld, is_st, base_rule, writes_z, supported;

  assign op    = op_e'(ir_q[31:27]);
  assign ra    = ir_q[23 +: RW];
  assign rb    = ir_q[19 +: RW];
  assign rc    = ir_q[15 +: RW];
  assign c_ext = {{(DATA_W-19){ir_q[18]}}, ir_q[18:0]};

  assign is_ld     = (op == OP_LD);
  assign is_st     = (op == OP_ST);
  assign base_rule = op inside {OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI};
  assign writes_z  = op inside {OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
                                OP_ADDI, OP_ANDI, OP_ORI};
  assign supported = writes_z || op inside {OP_LD, OP_ST, OP_NOP, OP_HALT};

  // armed_q marks that mem_req was already high last cycle, so an ack in the
  // same cycle the request rises is never taken.
  assign ack_ok = mem_ack && armed_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    y_d       = y_q;
    z_d       = z_q;
    illegal_d = illegal_q;
    armed_d   = 1'b0;
    wb_en     = 1'b0;
    wb_data   = is_ld ? mdr_q : z_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = mdr_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        armed_d = !ack_ok;
        if (ack_ok) begin
          ir_d    = mem_rdata[31:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        y_d = (base_rule && rb == '0) ? '0 : regs_q[rb];
        if (is_st) mdr_d = regs_q[ra];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        case (op)
          OP_ADD:  z_d = y_q + regs_q[rc];
          OP_SUB:  z_d = y_q - regs_q[rc];
          OP_AND:  z_d = y_q & regs_q[rc];
          OP_OR:   z_d = y_q | regs_q[rc];
          OP_ADDI, OP_LDI: z_d = y_q + c_ext;
          OP_ANDI: z_d = y_q & c_ext;
          OP_ORI:  z_d = y_q | c_ext;
          OP_LD, OP_ST: begin
            mar_d   = ADDR_W'(y_q + c_ext);
            state_d = S_MEM;
          end
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
        if (!supported) illegal_d = 1'b1;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = mar_q;
        mem_we   = is_st;
        armed_d  = !ack_ok;
        if (ack_ok) begin
          if (is_ld) mdr_d = mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        wb_en   = writes_z || is_ld;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      illegal_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      y_q       <= y_d;
      z_q       <= z_d;
      illegal_q <= illegal_d;
      armed_q   <= armed_d;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[ra] <= wb_data;
    end
  end

  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign pc_out    = pc_q;
  assign dbg_rdata = regs_q[dbg_rsel[RW-1:0]];

`ifdef SEQ_DP_TRACE_EN
  logic [ADDR_W-1:0] ipc_q;
  logic              retire_valid_q;
  logic [ADDR_W-1:0] retire_pc_q;
  logic [DATA_W-1:0] retire_wdata_q;
  logic              retire_now;

  assign retire_now = (state_d == S_WB) || (state_d == S_HALT && state_q != S_HALT);

  // Registered on the transition so the pulse coincides with the WB / HALT-entry cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ipc_q          <= '0;
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      retire_wdata_q <= '0;
    end else begin
      if (state_q == S_FETCH && ack_ok) ipc_q <= pc_q;
      retire_valid_q <= retire_now;
      if (retire_now) begin
        retire_pc_q    <= ipc_q;
        retire_wdata_q <= (state_d == S_WB && (writes_z || is_ld)) ?
                          (is_ld ? mdr_d : z_d) : '0;
      end
    end
  end

  assign retire_valid = retire_valid_q;
  assign retire_pc    = retire_pc_q;
  assign retire_wdata = retire_wdata_q;
`endif

endmodule
